binary_split_tree_ctrl: RTL and testbench



---
 rtl/binary_split_tree_ctrl_if.sv | 28 ++
 rtl/binary_split_tree_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_binary_split_tree_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/binary_split_tree_ctrl_if.sv
// Request/completion bundle of the splitter-tree sequencer.
// One valid/ready handshake plus a one-cycle completion report.
`timescale 1ns/1ps
interface binary_split_tree_ctrl_if #(
    parameter int DEPTH  = 3,
    parameter int HOLD_W = 8
);
    // Handshake: a request transfers on the rising clk edge where req_valid && req_ready.
    // req_leaf/req_hold matter only on that edge. req_ready is high only while idle.
    // done is a one-cycle pulse; done_leaf/done_aborted are meaningful only while done=1.
    logic              req_valid;
    logic              req_ready;
    logic [DEPTH-1:0]  req_leaf;
    logic [HOLD_W-1:0] req_hold;
    logic              done;
    logic [DEPTH-1:0]  done_leaf;
    logic              done_aborted;

    modport master (
        output req_valid, req_leaf, req_hold,
        input  req_ready, done, done_leaf, done_aborted
    );

    modport slave (
        input  req_valid, req_leaf, req_hold,
        output req_ready, done, done_leaf, done_aborted
    );
endinterface

// File: rtl/binary_split_tree_ctrl.sv
// Sequencer for a heap-indexed binary splitter tree: route the valve path,
// open the inlet for the requested time, drain, then report completion.
`timescale 1ns/1ps
module binary_split_tree_ctrl #(
    parameter  int DEPTH  = 3,
    parameter  int SETTLE = 4,
    parameter  int HOLD_W = 8,
    localparam int N      = (1 << DEPTH) - 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    binary_split_tree_ctrl_if.slave   req_if,
    input  logic                      abort,
    output logic [N-1:0]              valve_left,
    output logic [N-1:0]              valve_right,
    output logic                      inlet_open,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_FLOW  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    state_e            state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DEPTH-1:0]  leaf_q, leaf_d;
    logic              aborted_q, aborted_d;
    logic [N-1:0]      vl_q, vl_d;
    logic [N-1:0]      vr_q, vr_d;
    logic              inlet_q, inlet_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DEPTH-1:0]  done_leaf_q, done_leaf_d;
    logic              done_ab_q, done_ab_d;

    logic [N-1:0]      path_l, path_r;
    int                node;
    logic              accept;

    // Walk root to leaf, MSB of the leaf index first; bit 0 goes left, 1 goes right.
    always_comb begin
        path_l = '0;
        path_r = '0;
        node   = 0;
        for (int d = 0; d < DEPTH; d++) begin
            if (req_if.req_leaf[DEPTH-1-d]) begin
                path_r[node] = 1'b1;
                node         = 2 * node + 2;
            end else begin
                path_l[node] = 1'b1;
                node         = 2 * node + 1;
            end
        end
    end

    assign accept = req_if.req_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        hold_d      = hold_q;
        leaf_d      = leaf_q;
        aborted_d   = aborted_q;
        vl_d        = vl_q;
        vr_d        = vr_q;
        inlet_d     = 1'b0;
        ready_d     = 1'b0;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        done_leaf_d = done_leaf_q;
        done_ab_d   = done_ab_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_ROUTE;
                    leaf_d    = req_if.req_leaf;
                    hold_d    = req_if.req_hold;
                    aborted_d = 1'b0;
                    settle_d  = SETTLE_LOAD;
                    vl_d      = path_l;
                    vr_d      = path_r;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    vl_d    = '0;
                    vr_d    = '0;
                end
            end

            S_ROUTE: begin
                if (abort) begin
                    state_d   = S_DRAIN;
                    settle_d  = SETTLE_LOAD;
                    aborted_d = 1'b1;
                end else if (settle_q == 8'd0) begin
                    settle_d = SETTLE_LOAD;
                    if (hold_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        // hold_q becomes "FLOW cycles remaining after this one".
                        state_d = S_FLOW;
                        hold_d  = hold_q - 1'b1;
                        inlet_d = 1'b1;
                    end
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end

            S_FLOW: begin
                if (abort) begin
                    state_d   = S_DRAIN;
                    settle_d  = SETTLE_LOAD;
                    aborted_d = 1'b1;
                end else if (hold_q == '0) begin
                    state_d  = S_DRAIN;
                    settle_d = SETTLE_LOAD;
                end else begin
                    hold_d  = hold_q - 1'b1;
                    inlet_d = 1'b1;
                end
            end

            S_DRAIN: begin
                if (settle_q == 8'd0) begin
                    state_d     = S_IDLE;
                    vl_d        = '0;
                    vr_d        = '0;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    done_leaf_d = leaf_q;
                    done_ab_d   = aborted_q;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                vl_d    = '0;
                vr_d    = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            hold_q      <= '0;
            leaf_q      <= '0;
            aborted_q   <= 1'b0;
            vl_q        <= '0;
            vr_q        <= '0;
            inlet_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_leaf_q <= '0;
            done_ab_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            hold_q      <= hold_d;
            leaf_q      <= leaf_d;
            aborted_q   <= aborted_d;
            vl_q        <= vl_d;
            vr_q        <= vr_d;
            inlet_q     <= inlet_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_leaf_q <= done_leaf_d;
            done_ab_q   <= done_ab_d;
        end
    end

    assign valve_left          = vl_q;
    assign valve_right         = vr_q;
    assign inlet_open          = inlet_q;
    assign busy                = busy_q;
    assign dbg_state           = state_q;
    assign req_if.req_ready    = ready_q;
    assign req_if.done         = done_q;
    assign req_if.done_leaf    = done_leaf_q;
    assign req_if.done_aborted = done_ab_q;

endmodule

// File: tb/tb_binary_split_tree_ctrl.sv
// Self-checking bench for binary_split_tree_ctrl: directed vector table,
// hand-written corner sequences and randomized dispenses against a timing model.
`timescale 1ns/1ps
module tb_binary_split_tree_ctrl;
    localparam int DEPTH  = 3;
    localparam int SETTLE = 4;
    localparam int HOLD_W = 8;
    localparam int N      = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] vl, vr;
    logic         inlet, busy;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [DEPTH:0] exp_q[$];

    binary_split_tree_ctrl_if #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus ();

    binary_split_tree_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE), .HOLD_W(HOLD_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_if      (bus),
        .abort       (abort),
        .valve_left  (vl),
        .valve_right (vr),
        .inlet_open  (inlet),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           leaf;
        int           hold;
        int           abort_at;
        int           abort_acc;
        logic [N-1:0] vl;
        logic [N-1:0] vr;
        int           in_first;
        int           in_last;
        int           done_cyc;
        logic         ab;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", name, k, got, exp);
        end
    endtask

    // {valve_left, valve_right, inlet, busy, done, ready}
    function automatic logic [17:0] observe();
        return {vl, vr, inlet, busy, bus.done, bus.req_ready};
    endfunction

    // Leaf sits at heap slot N+leaf; climb to the root marking which child we came from.
    function automatic logic [2*N-1:0] model_path(input int leaf);
        logic [N-1:0] l, r;
        int c, p;
        l = '0;
        r = '0;
        c = N + leaf;
        while (c > 0) begin
            p = (c - 1) / 2;
            if (c == 2 * p + 1) l[p] = 1'b1;
            else r[p] = 1'b1;
            c = p;
        end
        return {l, r};
    endfunction

    task automatic run_check(input int leaf, input int hold, input int a, input int a_acc,
                             input logic [N-1:0] evl, input logic [N-1:0] evr,
                             input int in_f, input int in_l, input int done_c,
                             input logic eab, input string tag);
        logic [17:0]    exp;
        logic [DEPTH:0] exp_done;
        logic           in_on;
        exp_q.push_back({DEPTH'(leaf), eab});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_leaf  = DEPTH'(leaf);
        bus.req_hold  = HOLD_W'(hold);
        abort         = a_acc[0];
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_leaf  = DEPTH'($urandom);
        bus.req_hold  = HOLD_W'($urandom);
        abort         = 1'b0;
        for (int k = 1; k <= done_c + 1; k++) begin
            @(negedge clk);
            in_on = (in_f != 0) && (k >= in_f) && (k <= in_l);
            if (k < done_c) exp = {evl, evr, in_on, 1'b1, 1'b0, 1'b0};
            else if (k == done_c) exp = {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1};
            else exp = {{N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1};
            check({tag, "_cycle"}, k, 64'(observe()), 64'(exp));
            if (k == done_c) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_queue_empty"}, k, 64'(1), 64'(0));
                end else begin
                    exp_done = exp_q.pop_front();
                    check({tag, "_done_info"}, k, 64'({bus.done_leaf, bus.done_aborted}), 64'(exp_done));
                end
            end
            abort         = (k == a);
            bus.req_valid = ($urandom_range(0, 3) == 0) && (k < done_c);
        end
        abort         = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int leaf, hold, a, in_f, in_l, done_c;
        logic ab;
        logic [2*N-1:0] p;
        logic [2*N-1:0] p2, p6;
        logic [17:0] exp;

        tbl[0] = '{5, 3,   0, 0, 7'b0000100, 7'b0100001, 5, 7,   12,  1'b0};
        tbl[1] = '{0, 0,   0, 0, 7'b0001011, 7'b0000000, 0, 0,   9,   1'b0};
        tbl[2] = '{7, 10,  6, 0, 7'b0000000, 7'b1000101, 5, 6,   11,  1'b1};
        tbl[3] = '{3, 1,   0, 1, 7'b0000001, 7'b0010010, 5, 5,   10,  1'b0};
        tbl[4] = '{6, 5,   2, 0, 7'b1000000, 7'b0000101, 0, 0,   7,   1'b1};
        tbl[5] = '{4, 255, 0, 0, 7'b0100100, 7'b0000001, 5, 259, 264, 1'b0};
        tbl[6] = '{1, 2,   9, 0, 7'b0000011, 7'b0001000, 5, 6,   11,  1'b0};
        tbl[7] = '{2, 4,   4, 0, 7'b0010001, 7'b0000010, 0, 0,   9,   1'b1};
        tbl[8] = '{5, 2,   6, 0, 7'b0000100, 7'b0100001, 5, 6,   11,  1'b1};

        bus.req_valid = 1'b0;
        bus.req_leaf  = '0;
        bus.req_hold  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_outputs", 0, 64'(observe()), 64'(18'b1));
        check("reset_done_info", 0, 64'({bus.done_leaf, bus.done_aborted}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_check(tbl[i].leaf, tbl[i].hold, tbl[i].abort_at, tbl[i].abort_acc,
                      tbl[i].vl, tbl[i].vr, tbl[i].in_first, tbl[i].in_last,
                      tbl[i].done_cyc, tbl[i].ab, $sformatf("vec%0d", i));
        end

        // Back-to-back: second request held valid and accepted in the done cycle
        p2 = model_path(2);
        p6 = model_path(6);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_leaf  = 3'd2;
        bus.req_hold  = 8'd1;
        @(posedge clk);
        #1;
        bus.req_leaf  = 3'd6;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 10 || k == 20) exp = {{2*N{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1};
            else if (k < 10) exp = {p2, (k == 5), 1'b1, 1'b0, 1'b0};
            else if (k < 20) exp = {p6, (k == 15), 1'b1, 1'b0, 1'b0};
            else exp = {{2*N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1};
            check("b2b_cycle", k, 64'(observe()), 64'(exp));
            if (k == 10) check("b2b_first_done", k, 64'({bus.done_leaf, bus.done_aborted}), 64'({3'd2, 1'b0}));
            if (k == 20) check("b2b_second_done", k, 64'({bus.done_leaf, bus.done_aborted}), 64'({3'd6, 1'b0}));
            if (k == 11) bus.req_valid = 1'b0;
        end

        // Asynchronous reset in the middle of FLOW
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_leaf  = 3'd3;
        bus.req_hold  = 8'd20;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        p = model_path(3);
        check("flow_before_reset", 8, 64'(observe()), 64'({p, 1'b1, 1'b1, 1'b0, 1'b0}));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 8, 64'(observe()), 64'(18'b1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("post_reset_idle", k, 64'(observe()), 64'(18'b1));
        end

        // Randomized dispenses against the timing model
        for (int i = 0; i < 40; i++) begin
            leaf = $urandom_range(0, 7);
            hold = $urandom_range(0, 12);
            a    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * SETTLE + hold) : 0;
            p    = model_path(leaf);
            if (a >= 1 && a <= SETTLE + hold) begin
                ab     = 1'b1;
                in_f   = SETTLE + 1;
                in_l   = a;
                done_c = a + SETTLE + 1;
            end else begin
                ab     = 1'b0;
                in_f   = SETTLE + 1;
                in_l   = SETTLE + hold;
                done_c = 2 * SETTLE + hold + 1;
            end
            if (in_l < in_f) begin
                in_f = 0;
                in_l = 0;
            end
            run_check(leaf, hold, a, $urandom_range(0, 1), p[2*N-1:N], p[N-1:0],
                      in_f, in_l, done_c, ab, $sformatf("rand%0d", i));
        end

        check("queue_drained", 0, 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
